// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the sequential signed divider.
package sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } sdiv_state_t;

  // Counter must hold the value N itself, not just N-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module sdiv_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] next_rem,
  output logic [N-1:0] next_quo
);

  logic [N:0]   rem_sh;
  logic [N-1:0] diff;
  logic         fits;

  // When the trial fits the true difference is below divisor, so N bits suffice.
  always_comb begin
    rem_sh   = {rem, quo[N-1]};
    fits     = (rem_sh >= {1'b0, divisor});
    diff     = rem_sh[N-1:0] - divisor;
    next_rem = fits ? diff : rem_sh[N-1:0];
    next_quo = {quo[N-2:0], fits};
  end

endmodule

// File: rtl/sync_sdiv.sv
// N-bit sequential signed divider (restoring, N iterations plus a sign-fix cycle).
// Optional SDIV_UNSIGNED_EN adds a sign_en input selecting unsigned operation.
module sync_sdiv
  import sdiv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef SDIV_UNSIGNED_EN
  input  logic         sign_en,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  sdiv_state_t   state, next_state;
  logic [N-1:0]  rem, quo, divisor;
  logic [N-1:0]  next_rem, next_quo;
  logic [N-1:0]  abs_a, abs_b;
  logic [CW-1:0] count;
  logic          sign_q, sign_r, zero_flag;
  logic          signed_mode;

`ifdef SDIV_UNSIGNED_EN
  assign signed_mode = sign_en;
`else
  assign signed_mode = 1'b1;
`endif

  // N-bit negation keeps |-2^(N-1)| = 2^(N-1) as an unsigned magnitude.
  assign abs_a = (signed_mode && a[N-1]) ? -a : a;
  assign abs_b = (signed_mode && b[N-1]) ? -b : b;
  assign busy  = (state != IDLE);

  sdiv_step #(.N(N)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .next_rem(next_rem),
    .next_quo(next_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = (b == '0) ? FIX : CALC;
      CALC:    if (count == CW'(1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Divide by zero preloads quo/rem with the final answer so FIX needs no special case.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_flag   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            count <= CW'(N);
            if (b == '0) begin
              zero_flag <= 1'b1;
              rem       <= a;
              quo       <= '1;
              sign_q    <= 1'b0;
              sign_r    <= 1'b0;
            end else begin
              zero_flag <= 1'b0;
              rem       <= '0;
              quo       <= abs_a;
              divisor   <= abs_b;
              sign_q    <= signed_mode & (a[N-1] ^ b[N-1]);
              sign_r    <= signed_mode & a[N-1];
            end
          end
        end
        CALC: begin
          rem   <= next_rem;
          quo   <= next_quo;
          count <= count - CW'(1);
        end
        FIX: begin
          quotient    <= sign_q ? -quo : quo;
          remainder   <= sign_r ? -rem : rem;
          div_by_zero <= zero_flag;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_sdiv.sv
// Self-checking bench for sync_sdiv (N=8) using a queue scoreboard of expected results.
module tb_sync_sdiv;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
`ifdef SDIV_UNSIGNED_EN
  logic         sign_en;
`endif
  logic [N-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   pushes = 0;

  sync_sdiv #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef SDIV_UNSIGNED_EN
    .sign_en    (sign_en),
`endif
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: SV integer / and % truncate toward zero.
  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sg);
    exp_t e;
    int   x, y;
    e.tag = "";
    e.cyc = 0;
    if (bv == 0) begin
      e.q  = '1;
      e.r  = av;
      e.dz = 1'b1;
    end else begin
      if (sg) begin
        x = $signed(av);
        y = $signed(bv);
      end else begin
        x = int'(av);
        y = int'(bv);
      end
      e.q  = N'(x / y);
      e.r  = N'(x % y);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pushExpected(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sg,
                              input string tag);
    exp_t e;
    e     = model(av, bv, sg);
    e.cyc = cyc + ((bv == 0) ? 2 : N + 2);
    e.tag = tag;
    sb.push_back(e);
    pushes++;
  endtask

  // Drives a one-cycle start pulse; accepted requests are scored.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sg,
                               input bit accept, input string tag);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
`ifdef SDIV_UNSIGNED_EN
    sign_en = sg;
`endif
    if (accept) pushExpected(av, bv, sg, tag);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("[TB] FAIL %s_timeout observed=%0d pending expected=0", tag, sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_count++;
      checks++;
      assert (sb.size() > 0)
      else begin
        errors++;
        $error("[TB] FAIL unexpected_done observed=1 expected=0 at cycle %0d", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, "_quotient"}, 32'(quotient), 32'(e.q));
        checkOutput({e.tag, "_remainder"}, 32'(remainder), 32'(e.r));
        checkOutput({e.tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
        checkOutput({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int n;
    int dc;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SDIV_UNSIGNED_EN
    sign_en = 1'b1;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    applyStimulus(8'd100, 8'd7, 1'b1, 1'b1, "pos_pos");
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 32'(n), 32'd9);
    waitIdle("pos_pos");

    applyStimulus(8'h9C, 8'd7, 1'b1, 1'b1, "neg_pos");
    waitIdle("neg_pos");
    applyStimulus(8'd100, 8'hF9, 1'b1, 1'b1, "pos_neg");
    waitIdle("pos_neg");
    applyStimulus(8'h80, 8'hFF, 1'b1, 1'b1, "overflow");
    waitIdle("overflow");
    applyStimulus(8'h80, 8'd1, 1'b1, 1'b1, "min_by_one");
    waitIdle("min_by_one");

    applyStimulus(8'd5, 8'd0, 1'b1, 1'b1, "div_zero");
    waitIdle("div_zero");
    repeat (3) @(negedge clk);
    checkOutput("dz_held_flag", 32'(div_by_zero), 32'd1);
    checkOutput("dz_held_quotient", 32'(quotient), 32'hFF);
    applyStimulus(8'd6, 8'd3, 1'b1, 1'b1, "dz_clear");
    waitIdle("dz_clear");

    applyStimulus(8'd50, 8'd5, 1'b1, 1'b1, "busy_ignore");
    @(negedge clk);
    a     = 8'd9;
    b     = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle("busy_ignore");

    // A start presented while done is high must be accepted.
    applyStimulus(8'd77, 8'd9, 1'b1, 1'b1, "first_b2b");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) break;
    end
    a     = 8'hE7;
    b     = 8'd4;
    start = 1'b1;
    pushExpected(8'hE7, 8'd4, 1'b1, "start_on_done");
    @(negedge clk);
    start = 1'b0;
    waitIdle("start_on_done");

    applyStimulus(8'd100, 8'd7, 1'b1, 1'b1, "aborted");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    pushes--;
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quotient", 32'(quotient), 32'd0);
    checkOutput("abort_remainder", 32'(remainder), 32'd0);
    checkOutput("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    dc = done_count;
    repeat (12) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_count), 32'(dc));
    applyStimulus(8'd100, 8'd7, 1'b1, 1'b1, "after_abort");
    waitIdle("after_abort");

`ifdef SDIV_UNSIGNED_EN
    applyStimulus(8'hF0, 8'h10, 1'b0, 1'b1, "unsigned");
    waitIdle("unsigned");
    applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1, "unsigned_zero");
    waitIdle("unsigned_zero");
`endif

    repeat (3) @(negedge clk);
    checkOutput("done_total", 32'(done_count), 32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
